// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: captures one word per valid_rx high period,
// tracks per-entry error flags, overrun and saturating error statistics.
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DROP_ERRORED = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_rx,
  input  logic [DATA_BITS-1:0]    RxData,
  input  logic                    Parity_error,
  input  logic                    Stop_error,
  input  logic                    rd_en,
  output logic [DATA_BITS-1:0]    rd_data,
  output logic                    rd_perr,
  output logic                    rd_serr,
  output logic                    rd_valid,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overrun,
  input  logic                    clr_overrun,
  output logic [7:0]              perr_cnt,
  output logic [7:0]              serr_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic                 serr;
    logic                 perr;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  entry_t         mem [DEPTH];
  entry_t         wr_entry;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           valid_q;
  logic           frame_evt;
  logic           storable;
  logic           push;
  logic           pop;
  logic           overrun_set;
  logic [CW-1:0]  count_nxt;

  // Frame qualification and push/pop arbitration; a pop needs an entry already present.
  always_comb begin
    frame_evt   = valid_rx & ~valid_q;
    storable    = frame_evt & ~((DROP_ERRORED != 0) & (Parity_error | Stop_error));
    pop         = rd_en & ~empty;
    push        = storable & (~full | pop);
    overrun_set = storable & full & ~pop;
    count_nxt   = count + CW'(push) - CW'(pop);
    wr_entry    = '{serr: Stop_error, perr: Parity_error, data: RxData};
  end

  // Storage array carries no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_perr  <= 1'b0;
      rd_serr  <= 1'b0;
      overrun  <= 1'b0;
      perr_cnt <= 8'd0;
      serr_cnt <= 8'd0;
    end else begin
      valid_q  <= valid_rx;
      rd_valid <= pop;
      count    <= count_nxt;
      empty    <= (count_nxt == CW'(0));
      full     <= (count_nxt == CW'(DEPTH));
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        rd_data <= mem[rd_ptr].data;
        rd_perr <= mem[rd_ptr].perr;
        rd_serr <= mem[rd_ptr].serr;
      end
      // Set has priority over clear so a lost frame is never hidden.
      if (overrun_set)      overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
      if (frame_evt && Parity_error && perr_cnt != 8'hFF) perr_cnt <= perr_cnt + 8'd1;
      if (frame_evt && Stop_error   && serr_cnt != 8'hFF) serr_cnt <= serr_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a table of single-cycle vectors plus
// hand-written sequences for full/overrun, error dropping, saturation and reset.
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic       valid_rx;
  logic [7:0] rx_data;
  logic       perr_in;
  logic       serr_in;
  logic       rd_en;
  logic       clr_overrun;

  logic [7:0] a_rd_data, b_rd_data;
  logic       a_rd_perr, b_rd_perr, a_rd_serr, b_rd_serr, a_rd_valid, b_rd_valid;
  logic       a_empty, b_empty, a_full, b_full, a_overrun, b_overrun;
  logic [4:0] a_count, b_count;
  logic [7:0] a_perr_cnt, b_perr_cnt, a_serr_cnt, b_serr_cnt;

  int tests = 0;
  int fails = 0;

  uart_rx_fifo #(.DATA_BITS(8), .DEPTH(16), .DROP_ERRORED(0)) dut_a (
    .clk(clk), .reset(reset), .valid_rx(valid_rx), .RxData(rx_data),
    .Parity_error(perr_in), .Stop_error(serr_in), .rd_en(rd_en),
    .rd_data(a_rd_data), .rd_perr(a_rd_perr), .rd_serr(a_rd_serr), .rd_valid(a_rd_valid),
    .empty(a_empty), .full(a_full), .count(a_count), .overrun(a_overrun),
    .clr_overrun(clr_overrun), .perr_cnt(a_perr_cnt), .serr_cnt(a_serr_cnt)
  );

  uart_rx_fifo #(.DATA_BITS(8), .DEPTH(16), .DROP_ERRORED(1)) dut_b (
    .clk(clk), .reset(reset), .valid_rx(valid_rx), .RxData(rx_data),
    .Parity_error(perr_in), .Stop_error(serr_in), .rd_en(rd_en),
    .rd_data(b_rd_data), .rd_perr(b_rd_perr), .rd_serr(b_rd_serr), .rd_valid(b_rd_valid),
    .empty(b_empty), .full(b_full), .count(b_count), .overrun(b_overrun),
    .clr_overrun(clr_overrun), .perr_cnt(b_perr_cnt), .serr_cnt(b_serr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       pe;
    logic       se;
    logic       rd;
    logic       exp_rv;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_se;
    logic [4:0] exp_cnt;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    valid_rx = 1'b0; rx_data = 8'h00; perr_in = 1'b0; serr_in = 1'b0;
    rd_en = 1'b0; clr_overrun = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // One frame: valid_rx high one cycle, then low one cycle.
  task automatic send(input logic [7:0] d, input logic pe, input logic se);
    valid_rx = 1'b1; rx_data = d; perr_in = pe; serr_in = se;
    step();
    valid_rx = 1'b0; perr_in = 1'b0; serr_in = 1'b0;
    step();
  endtask

  // Pop n entries back-to-back, expecting consecutive bytes from first.
  task automatic pop_seq(input string nm, input int n, input logic [7:0] first);
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      chk({nm, "_rv"}, 32'(a_rd_valid), 32'd1);
      chk({nm, "_data"}, 32'(a_rd_data), 32'(8'(first + 8'(i))));
    end
    rd_en = 1'b0;
    step();
  endtask

  initial begin
    logic [18:0] act;
    logic [18:0] exp;

    // v d pe se rd | rv data pe se cnt empty full ovr
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};

    reset = 1'b1;
    do_reset();

    // Reset state
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_flags", 32'({a_empty, a_full, a_rd_valid, a_overrun}), 32'b1000);
    chk("rst_rd", 32'({a_rd_data, a_rd_perr, a_rd_serr}), 32'd0);
    chk("rst_errcnt", 32'({a_perr_cnt, a_serr_cnt}), 32'd0);

    // Table: single event per high period, empty read, no-bypass, simultaneous push/pop
    for (int i = 0; i < 14; i++) begin
      valid_rx = vecs[i].v; rx_data = vecs[i].d; perr_in = vecs[i].pe;
      serr_in = vecs[i].se; rd_en = vecs[i].rd;
      step();
      act = {a_rd_valid, a_rd_data, a_rd_perr, a_rd_serr, a_count, a_empty, a_full, a_overrun};
      exp = {vecs[i].exp_rv, vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_se, vecs[i].exp_cnt,
             vecs[i].exp_empty, vecs[i].exp_full, vecs[i].exp_ovr};
      chk($sformatf("vec%0d", i), 32'(act), 32'(exp));
    end
    idle();
    step();
    chk("vec_perr_cnt", 32'(a_perr_cnt), 32'd1);
    chk("vec_serr_cnt", 32'(a_serr_cnt), 32'd2);

    // Fill, overrun on 17th frame, clear, drain in order
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b0);
    chk("fill_full", 32'({a_full, a_overrun}), 32'b10);
    send(8'h55, 1'b0, 1'b0);
    chk("ovr_count", 32'(a_count), 32'd16);
    chk("ovr_flags", 32'({a_full, a_overrun, a_empty}), 32'b110);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("ovr_clear", 32'(a_overrun), 32'd0);
    pop_seq("drain", 16, 8'h00);
    chk("drain_empty", 32'({a_empty, a_count}), 32'({1'b1, 5'd0}));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("drain_no55", 32'({a_rd_valid, a_rd_data}), 32'({1'b0, 8'h0F}));

    // Refill; overrun set beats a same-cycle clear
    for (int i = 0; i < 16; i++) send(8'(8'h10 + 8'(i)), 1'b0, 1'b0);
    valid_rx = 1'b1; rx_data = 8'h99; clr_overrun = 1'b1;
    step();
    chk("set_wins", 32'({a_overrun, a_count}), 32'({1'b1, 5'd16}));
    valid_rx = 1'b0;
    step();
    clr_overrun = 1'b0;
    chk("clr_after", 32'(a_overrun), 32'd0);

    // Full with simultaneous frame and pop
    valid_rx = 1'b1; rx_data = 8'hAA; rd_en = 1'b1;
    step();
    valid_rx = 1'b0; rd_en = 1'b0;
    chk("fullrw_pop", 32'({a_rd_valid, a_rd_data}), 32'({1'b1, 8'h10}));
    chk("fullrw_state", 32'({a_count, a_full, a_overrun}), 32'({5'd16, 1'b1, 1'b0}));
    step();
    pop_seq("fullrw_drain", 15, 8'h11);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("fullrw_last", 32'({a_rd_valid, a_rd_data, a_empty}), 32'({1'b1, 8'hAA, 1'b1}));
    step();

    // Error dropping, DROP_ERRORED=0 (A) vs 1 (B)
    do_reset();
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    chk("drop_perrcnt", 32'({a_perr_cnt, b_perr_cnt}), 32'({8'd1, 8'd1}));
    chk("drop_count", 32'({a_count, b_count}), 32'({5'd2, 5'd1}));
    rd_en = 1'b1;
    step();
    chk("drop_a_first", 32'({a_rd_valid, a_rd_data, a_rd_perr}), 32'({1'b1, 8'h11, 1'b1}));
    chk("drop_b_first", 32'({b_rd_valid, b_rd_data, b_rd_perr}), 32'({1'b1, 8'h22, 1'b0}));
    step();
    rd_en = 1'b0;
    chk("drop_a_second", 32'({a_rd_valid, a_rd_data, a_rd_perr}), 32'({1'b1, 8'h22, 1'b0}));
    chk("drop_b_second", 32'({b_rd_valid, b_empty}), 32'({1'b0, 1'b1}));

    // 300 stop-error frames with continuous popping
    do_reset();
    rd_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      valid_rx = 1'b1; rx_data = 8'(i); serr_in = 1'b1;
      step();
      if (i == 9)   chk("sat_cnt10", 32'(a_serr_cnt), 32'd10);
      if (i == 254) chk("sat_cnt255", 32'(a_serr_cnt), 32'd255);
      valid_rx = 1'b0; serr_in = 1'b0;
      step();
    end
    rd_en = 1'b0;
    step();
    chk("sat_final", 32'({a_serr_cnt, b_serr_cnt}), 32'({8'd255, 8'd255}));
    chk("sat_noovr", 32'({a_overrun, a_perr_cnt, a_count}), 32'({1'b0, 8'd0, 5'd0}));

    // Reset mid-operation with 5 entries and overrun set
    do_reset();
    for (int i = 0; i < 17; i++) send(8'(8'h40 + 8'(i)), 1'b0, 1'b0);
    pop_seq("pre_rst", 11, 8'h40);
    chk("pre_rst_state", 32'({a_count, a_overrun}), 32'({5'd5, 1'b1}));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst", 32'({a_count, a_empty, a_overrun, a_full, a_rd_valid}),
        32'({5'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("post_rst_rd", 32'({a_rd_valid, a_count, a_rd_data}), 32'({1'b0, 5'd0, 8'h00}));

    // valid_rx already high at reset release counts as a frame
    valid_rx = 1'b1; rx_data = 8'h6B; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rel_in_rst", 32'(a_count), 32'd0);
    step();
    chk("rel_event", 32'({a_count, a_empty}), 32'({5'd1, 1'b0}));
    step();
    chk("rel_single", 32'(a_count), 32'd1);
    valid_rx = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("rel_data", 32'({a_rd_valid, a_rd_data}), 32'({1'b1, 8'h6B}));
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: width of each received data word.
REQ-002 SHALL have parameter DEPTH, default 16: number of entries; power of two, >= 2.
REQ-003 SHALL have parameter DROP_ERRORED, default 0: 1 discards frames with any error flag; 0 stores them.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port valid_rx, input, 1: receiver frame-complete flag, synchronous to clk, may stay high several cycles.
REQ-007 SHALL have port RxData, input, DATA_BITS: received word, stable while valid_rx is high.
REQ-008 SHALL have port Parity_error, input, 1: parity error for the current frame.
REQ-009 SHALL have port Stop_error, input, 1: stop-bit error for the current frame.
REQ-010 SHALL have port rd_en, input, 1: read request from the consumer.
REQ-011 SHALL have port rd_data, output, DATA_BITS: data of the last popped entry.
REQ-012 SHALL have port rd_perr, output, 1: parity flag of the last popped entry.
REQ-013 SHALL have port rd_serr, output, 1: stop flag of the last popped entry.
REQ-014 SHALL have port rd_valid, output, 1: one-cycle pulse marking rd_data/rd_perr/rd_serr valid.
REQ-015 SHALL have port empty, output, 1: count == 0.
REQ-016 SHALL have port full, output, 1: count == DEPTH.
REQ-017 SHALL have port count, output, $clog2(DEPTH)+1: current occupancy.
REQ-018 SHALL have port overrun, output, 1: sticky flag, frame lost because the FIFO was full.
REQ-019 SHALL have port clr_overrun, input, 1: clears overrun.
REQ-020 SHALL have port perr_cnt, output, 8: saturating count of frames with Parity_error.
REQ-021 SHALL have port serr_cnt, output, 8: saturating count of frames with Stop_error.

Function
REQ-022 SHALL register valid_rx into valid_q each cycle; frame event = valid_rx & ~valid_q, so one event per valid_rx high period.
REQ-023 SHALL, on a frame event, sample RxData, Parity_error and Stop_error in that same cycle.
REQ-024 SHALL, on a frame event accepted for storage, write {Stop_error, Parity_error, RxData} at wr_ptr and increment wr_ptr modulo DEPTH; empty deasserts and count increments after that edge.
REQ-025 SHALL, when DROP_ERRORED=1 and either error flag is set, not store the frame; the error counters still update.
REQ-026 SHALL increment perr_cnt and serr_cnt on frame events with the matching flag set; each counter holds at 255.
REQ-027 SHALL, on rd_en with empty=0, register the entry at rd_ptr onto rd_data/rd_perr/rd_serr, pulse rd_valid high the next cycle, and increment rd_ptr modulo DEPTH (1-cycle read latency).
REQ-028 SHALL ignore rd_en while empty=1: no pointer change, rd_valid stays 0, rd_data holds.
REQ-029 SHALL keep rd_data/rd_perr/rd_serr unchanged between pops.
REQ-030 SHALL, on a storable frame event with full=1 and no same-cycle pop, drop the frame and set overrun.
REQ-031 SHALL, on a storable frame event with full=1 and a same-cycle pop, perform both; count stays DEPTH.
REQ-032 SHALL, on a frame event with rd_en while empty=1, store the frame and ignore the read (no bypass); count becomes 1.
REQ-033 SHALL, on a simultaneous write and pop when not empty and not full, leave count unchanged.
REQ-034 SHALL clear overrun on clr_overrun; if a set condition occurs in the same cycle, set wins.
REQ-035 SHALL derive count from a dedicated occupancy register, never from pointer subtraction alone.

Reset
REQ-036 SHALL, while reset=1 at a clock edge, set wr_ptr, rd_ptr and count to 0, empty=1, full=0, rd_valid=0, rd_data=0, rd_perr=0, rd_serr=0, overrun=0, perr_cnt=0, serr_cnt=0 and valid_q=0.
REQ-037 SHALL, on reset asserted mid-operation, discard all stored entries; memory contents need not be cleared.
REQ-038 SHALL, if valid_rx is already high when reset releases, treat it as a new frame event in the first cycle after reset.

Verification
REQ-039 Bench SHALL drive valid_rx high for 3 cycles with RxData=0xA5 and no errors, then one rd_en -> exactly one entry; rd_valid pulses once with rd_data=0xA5, perr=serr=0; empty returns to 1.
REQ-040 Bench SHALL write DEPTH frames 0x00..0x0F, then a 17th frame 0x55 -> full=1, overrun=1, count=16; popping all 16 returns 0x00..0x0F in order, and 0x55 never appears.
REQ-041 Bench SHALL, with full=1, assert a frame event and rd_en in the same cycle -> count stays 16; the oldest entry is popped; the new byte is stored last; overrun stays 0.
REQ-042 Bench SHALL, with DROP_ERRORED=1, send 0x11 with Parity_error=1, then 0x22 clean -> perr_cnt=1; the only stored entry is 0x22. With DROP_ERRORED=0 the same stimulus stores 0x11 with rd_perr=1.
REQ-043 Bench SHALL send 300 frames with Stop_error=1 while popping continuously -> serr_cnt saturates at 255; no overrun occurs.
REQ-044 Bench SHALL assert reset with 5 entries stored and overrun=1 -> next cycle count=0, empty=1, overrun=0; a subsequent rd_en produces no rd_valid.
